// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, driving an external arctan LUT.
// Optional macro CORDIC_QUADRANT_EN pre-rotates angles beyond +/-pi/2 so the full Q2.16 span converges.
module cordic_rotator #(
    parameter int                 ITERATIONS = 16,
    parameter logic signed [17:0] K_INIT     = 18'sd39797
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [17:0] angle_in,
    output logic [4:0]         lut_index,
    input  logic signed [17:0] lut_angle,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [17:0] cos_out,
    output logic signed [17:0] sin_out,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid/cos_out/sin_out stay stable until that edge, and in_ready is high only in IDLE.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic signed [17:0] HALF_PI = 18'sd102944;

    state_t             state, state_next;
    logic signed [17:0] x, y, z;
    logic [4:0]         iter;
    logic signed [17:0] x_sh, y_sh, x_next, y_next, z_next;
    logic signed [17:0] x_load, y_load, z_load;
    logic               last_iter;
    logic               accept;

    assign accept    = in_valid && in_ready;
    assign last_iter = (iter == 5'(ITERATIONS - 1));

    // iter doubles as the LUT index; it is frozen on the final rotation so the index holds afterwards.
    assign lut_index = iter;

    assign x_sh = x >>> iter;
    assign y_sh = y >>> iter;

    always_comb begin
        x_next = x - y_sh;
        y_next = y + x_sh;
        z_next = z - lut_angle;
        if (z[17]) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + lut_angle;
        end
    end

    always_comb begin
        x_load = K_INIT;
        y_load = '0;
        z_load = angle_in;
`ifdef CORDIC_QUADRANT_EN
        if (angle_in > HALF_PI) begin
            x_load = '0;
            y_load = K_INIT;
            z_load = angle_in - HALF_PI;
        end else if (angle_in < -HALF_PI) begin
            x_load = '0;
            y_load = -K_INIT;
            z_load = angle_in + HALF_PI;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ROTATE;
            ROTATE:  if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            iter      <= '0;
            cos_out   <= '0;
            sin_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x    <= x_load;
                        y    <= y_load;
                        z    <= z_load;
                        iter <= '0;
                    end
                end
                ROTATE: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    if (last_iter) begin
                        cos_out   <= x_next;
                        sin_out   <= y_next;
                        out_valid <= 1'b1;
                    end else begin
                        iter <= iter + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rotator.sv
// Bench for cordic_rotator: supplies the arctan LUT, runs directed and random angles, checks against
// an ideal cos/sin (tolerance) and a bit-exact fixed-point CORDIC reference.
module tb_cordic_rotator;

    localparam int ITER = 16;
    localparam int K    = 39797;
    localparam int TOL  = 8;

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] angle_in;
    logic [4:0]         lut_index;
    logic signed [17:0] lut_angle;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] cos_out;
    logic signed [17:0] sin_out;
    logic               busy;
    logic [1:0]         state_dbg;

    logic signed [17:0] atan_tab [0:31];

    int errors = 0;
    int checks = 0;

    cordic_rotator #(.ITERATIONS(ITER), .K_INIT(18'sd39797)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .lut_index (lut_index),
        .lut_angle (lut_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign lut_angle = atan_tab[lut_index];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        checks++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Bit-exact reference: the textbook CORDIC rotation with 18-bit wrapping values.
    function automatic void model(input int ang, output int c, output int s);
        logic signed [17:0] xm, ym, zm, xs, ys;
        xm = 18'(K);
        ym = '0;
        zm = 18'(ang);
`ifdef CORDIC_QUADRANT_EN
        if (ang > 102944) begin
            xm = '0; ym = 18'(K); zm = 18'(ang - 102944);
        end else if (ang < -102944) begin
            xm = '0; ym = 18'(-K); zm = 18'(ang + 102944);
        end
`endif
        for (int i = 0; i < ITER; i++) begin
            xs = xm >>> i;
            ys = ym >>> i;
            if (zm < 0) begin
                xm = xm + ys; ym = ym - xs; zm = zm + atan_tab[i];
            end else begin
                xm = xm - ys; ym = ym + xs; zm = zm - atan_tab[i];
            end
        end
        c = int'(xm);
        s = int'(ym);
    endfunction

    function automatic int ideal_cos(input int ang);
        return int'($cos(real'(ang) / 65536.0) * 65536.0);
    endfunction

    function automatic int ideal_sin(input int ang);
        return int'($sin(real'(ang) / 65536.0) * 65536.0);
    endfunction

    // Accept an angle, wait (bounded) for the result and check latency and exact value.
    task automatic run_op(input int ang, input bit pulse, input bit check_lut);
        int cycles;
        int ec, es;
        bit lut_ok;
        bit ready_ok;
        in_valid = 1'b1;
        angle_in = 18'(ang);
        tick();
        in_valid = 1'b0;
        cycles   = 0;
        lut_ok   = 1'b1;
        ready_ok = 1'b1;
        while (!out_valid && cycles < 100) begin
            if (lut_index !== 5'(cycles)) lut_ok = 1'b0;
            if (in_ready !== 1'b0 || busy !== 1'b1) ready_ok = 1'b0;
            if (pulse && cycles == 5) begin
                in_valid = 1'b1;
                angle_in = '0;
            end
            tick();
            in_valid = 1'b0;
            cycles++;
        end
        check("latency", cycles, ITER);
        check("busy_during_rotate", int'(ready_ok), 1);
        if (check_lut) check("lut_index_steps", int'(lut_ok), 1);
        model(ang, ec, es);
        check("cos_exact", int'(cos_out), ec);
        check("sin_exact", int'(sin_out), es);
    endtask

    // Hold out_ready low for 'hold' cycles, then complete the output transfer.
    task automatic drain(input int ang, input int hold);
        int ec, es;
        bit stable;
        model(ang, ec, es);
        stable = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (out_valid !== 1'b1 || int'(cos_out) != ec || int'(sin_out) != es) stable = 1'b0;
        end
        check("hold_stable", int'(stable), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_cleared", int'(out_valid), 0);
        check("in_ready_after_done", int'(in_ready), 1);
    endtask

    initial begin
        int ang;
        int ec, es;
        bit quiet;
        real r;

        r = 1.0;
        for (int i = 0; i < 32; i++) begin
            atan_tab[i] = (i < 18) ? 18'(int'($atan(r) * 65536.0)) : '0;
            r = r / 2.0;
        end

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        angle_in  = '0;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_cos", int'(cos_out), 0);
        check("rst_sin", int'(sin_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_lut_index", int'(lut_index), 0);
        check("rst_state", int'(state_dbg), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        run_op(0, 1'b0, 1'b0);
        check_tol("cos_zero", int'(cos_out), 65536, TOL);
        check_tol("sin_zero", int'(sin_out), 0, TOL);
        drain(0, 1);

        run_op(51472, 1'b0, 1'b0);
        check_tol("cos_pi4", int'(cos_out), 46341, TOL);
        check_tol("sin_pi4", int'(sin_out), 46341, TOL);
        drain(51472, 5);

        run_op(-34315, 1'b0, 1'b1);
        check_tol("cos_mpi6", int'(cos_out), 56756, TOL);
        check_tol("sin_mpi6", int'(sin_out), -32768, TOL);
        check("lut_index_hold_done", int'(lut_index), ITER - 1);
        drain(-34315, 2);
        check("lut_index_hold_idle", int'(lut_index), ITER - 1);
        model(-34315, ec, es);
        check("cos_kept_idle", int'(cos_out), ec);

        // A request during rotation must be dropped, not queued.
        run_op(40000, 1'b1, 1'b0);
        drain(40000, 0);
        quiet = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("no_second_result", int'(quiet), 1);

        // Asynchronous abort in the middle of a rotation.
        in_valid = 1'b1;
        angle_in = 18'(30000);
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("abort_at_iter7", int'(lut_index), 7);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_cos", int'(cos_out), 0);
        check("abort_sin", int'(sin_out), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        tick();
        reset_n = 1'b1;
        tick();

        run_op(32768, 1'b0, 1'b1);
        check_tol("cos_half", int'(cos_out), ideal_cos(32768), TOL);
        check_tol("sin_half", int'(sin_out), ideal_sin(32768), TOL);
        drain(32768, 1);

`ifdef CORDIC_QUADRANT_EN
        run_op(124518, 1'b0, 1'b0);
        check_tol("cos_1p9", int'(cos_out), -21188, TOL);
        check_tol("sin_1p9", int'(sin_out), 62018, TOL);
        drain(124518, 1);
        run_op(-124518, 1'b0, 1'b0);
        check_tol("cos_m1p9", int'(cos_out), -21188, TOL);
        check_tol("sin_m1p9", int'(sin_out), -62018, TOL);
        drain(-124518, 1);
`endif

        for (int n = 0; n < 24; n++) begin
            ang = int'($urandom_range(0, 2 * 114249)) - 114249;
            run_op(ang, 1'b0, 1'b0);
            drain(ang, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
